// File: rtl/scale_v_seq_if.sv
// Operand/result handshake bundle for the scale_v_seq vector scaler.
interface scale_v_seq_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] s;
  logic [31:0] ax;
  logic [31:0] ay;
  logic [31:0] az;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] cx;
  logic [31:0] cy;
  logic [31:0] cz;
  logic        ovf;

  // Producer/consumer side (drives operands, accepts results)
  modport master (
    output in_valid, s, ax, ay, az, out_ready,
    input  in_ready, out_valid, cx, cy, cz, ovf
  );

  // Scaler side
  modport slave (
    input  in_valid, s, ax, ay, az, out_ready,
    output in_ready, out_valid, cx, cy, cz, ovf
  );
endinterface

// File: rtl/scale_v_seq.sv
// Fixed-point scalar-times-vector unit: one shared 32x32 signed multiplier
// stepped over x, y, z, with per-component saturation and a sticky overflow flag.
module scale_v_seq #(
  parameter int unsigned FRAC = 16
) (
  input  logic         clk,
  input  logic         rst,
  scale_v_seq_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    MX   = 3'd1,
    MY   = 3'd2,
    MZ   = 3'd3,
    DONE = 3'd4
  } state_e;

  state_e             state_q;
  logic signed [31:0] s_q;
  logic signed [31:0] ax_q;
  logic signed [31:0] ay_q;
  logic signed [31:0] az_q;
  logic [31:0]        cx_q;
  logic [31:0]        cy_q;
  logic [31:0]        cz_q;
  logic               ovf_q;
  logic               in_ready_q;
  logic               out_valid_q;

  logic signed [31:0] a_sel_d;
  logic signed [63:0] prod_d;
  logic signed [63:0] shifted_d;
  logic               sat_d;
  logic [31:0]        res_d;

  // Shared multiplier: pick the component for the current step, scale and saturate
  always_comb begin
    a_sel_d = az_q;
    if (state_q == MX) a_sel_d = ax_q;
    else if (state_q == MY) a_sel_d = ay_q;
    prod_d    = $signed({{32{s_q[31]}}, s_q}) * $signed({{32{a_sel_d[31]}}, a_sel_d});
    shifted_d = prod_d >>> FRAC;
    // Result fits only if everything above bit 31 of the shifted product is sign extension
    sat_d     = !((shifted_d[63:31] == '0) || (shifted_d[63:31] == '1));
    res_d     = shifted_d[31:0];
    if (sat_d) res_d = prod_d[63] ? 32'h8000_0000 : 32'h7FFF_FFFF;
  end

  // Control FSM with registered handshake and result outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      s_q         <= '0;
      ax_q        <= '0;
      ay_q        <= '0;
      az_q        <= '0;
      cx_q        <= '0;
      cy_q        <= '0;
      cz_q        <= '0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            s_q        <= bus.s;
            ax_q       <= bus.ax;
            ay_q       <= bus.ay;
            az_q       <= bus.az;
            ovf_q      <= 1'b0;
            in_ready_q <= 1'b0;
            state_q    <= MX;
          end
        end
        MX: begin
          cx_q    <= res_d;
          ovf_q   <= ovf_q | sat_d;
          state_q <= MY;
        end
        MY: begin
          cy_q    <= res_d;
          ovf_q   <= ovf_q | sat_d;
          state_q <= MZ;
        end
        MZ: begin
          cz_q        <= res_d;
          ovf_q       <= ovf_q | sat_d;
          out_valid_q <= 1'b1;
          state_q     <= DONE;
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.cx        = cx_q;
  assign bus.cy        = cy_q;
  assign bus.cz        = cz_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_scale_v_seq.sv
// Directed self-checking bench for scale_v_seq.
module tb_scale_v_seq;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  // Columns: s, ax, ay, az, cx, cy, cz, ovf
  logic [31:0] tv [3][8];

  scale_v_seq_if bus ();

  scale_v_seq #(.FRAC(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running clock, period 10
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int i);
    bus.s  = tv[i][0];
    bus.ax = tv[i][1];
    bus.ay = tv[i][2];
    bus.az = tv[i][3];
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_result(input string tag, input int i);
    chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd1);
    chk({tag, "_in_ready"},  32'(bus.in_ready),  32'd0);
    chk({tag, "_cx"},  bus.cx, tv[i][4]);
    chk({tag, "_cy"},  bus.cy, tv[i][5]);
    chk({tag, "_cz"},  bus.cz, tv[i][6]);
    chk({tag, "_ovf"}, 32'(bus.ovf), tv[i][7]);
  endtask

  // Accept vector i, verify the k+3 latency and result; optionally release it
  task automatic run_op(input string tag, input int i, input bit release_it);
    drive(i);
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    bus.s  = $urandom;
    bus.ax = $urandom;
    bus.ay = $urandom;
    bus.az = $urandom;
    chk({tag, "_busy_ready"}, 32'(bus.in_ready), 32'd0);
    chk({tag, "_k1_valid"}, 32'(bus.out_valid), 32'd0);
    tick();
    chk({tag, "_k2_valid"}, 32'(bus.out_valid), 32'd0);
    tick();
    chk({tag, "_k3_valid"}, 32'(bus.out_valid), 32'd0);
    tick();
    check_result(tag, i);
    if (release_it) begin
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      chk({tag, "_idle_valid"}, 32'(bus.out_valid), 32'd0);
      chk({tag, "_idle_ready"}, 32'(bus.in_ready), 32'd1);
      chk({tag, "_idle_cx_hold"}, bus.cx, tv[i][4]);
      chk({tag, "_idle_ovf_hold"}, 32'(bus.ovf), tv[i][7]);
    end
  endtask

  initial begin
    int  cyc;
    int  last_t;
    int  n_in;
    int  n_out;
    logic prev_ready;

    n_cmp = 0;
    n_err = 0;
    clk   = 1'b0;
    rst   = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.s  = '0;
    bus.ax = '0;
    bus.ay = '0;
    bus.az = '0;

    tv[0] = '{32'h0002_0000, 32'h0001_0000, 32'hFFFF_0000, 32'h0000_8000,
              32'h0002_0000, 32'hFFFE_0000, 32'h0001_0000, 32'd0};
    tv[1] = '{32'h0100_0000, 32'h0100_0000, 32'hFF00_0000, 32'h0000_0001,
              32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_0100, 32'd1};
    tv[2] = '{32'h0000_8000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000,
              32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000, 32'd0};

    // Reset state
    tick();
    tick();
    chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_cx", bus.cx, 32'd0);
    chk("rst_cy", bus.cy, 32'd0);
    chk("rst_cz", bus.cz, 32'd0);
    chk("rst_ovf", 32'(bus.ovf), 32'd0);
    rst = 1'b0;
    tick();
    chk("idle_no_start", 32'(bus.in_ready), 32'd1);

    // Basic, saturation, truncation
    run_op("basic", 0, 1'b1);
    run_op("sat",   1, 1'b1);
    run_op("trunc", 2, 1'b1);

    // Backpressure: hold result 10 cycles while in_valid pulses and inputs toggle
    run_op("bp", 1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = i[0];
      bus.s  = $urandom;
      bus.ax = $urandom;
      bus.ay = $urandom;
      bus.az = $urandom;
      tick();
      check_result("bp_hold", 1);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("bp_release_valid", 32'(bus.out_valid), 32'd0);
    chk("bp_release_ready", 32'(bus.in_ready), 32'd1);
    repeat (4) begin
      tick();
      chk("bp_once_valid", 32'(bus.out_valid), 32'd0);
    end

    // Back-to-back: three operations, results 5 cycles apart
    n_in   = 0;
    n_out  = 0;
    cyc    = 0;
    last_t = 0;
    bus.out_ready = 1'b1;
    drive(0);
    bus.in_valid = 1'b1;
    prev_ready = bus.in_ready;
    while (n_out < 3 && cyc < 60) begin
      tick();
      cyc++;
      if (prev_ready && bus.in_valid) begin
        n_in++;
        if (n_in < 3) drive(n_in);
        else bus.in_valid = 1'b0;
      end
      if (bus.out_valid) begin
        chk("b2b_cx", bus.cx, tv[n_out][4]);
        chk("b2b_cy", bus.cy, tv[n_out][5]);
        chk("b2b_cz", bus.cz, tv[n_out][6]);
        chk("b2b_ovf", 32'(bus.ovf), tv[n_out][7]);
        if (n_out > 0) chk("b2b_gap", 32'(cyc - last_t), 32'd5);
        last_t = cyc;
        n_out++;
      end
      prev_ready = bus.in_ready;
    end
    chk("b2b_count", 32'(n_out), 32'd3);
    bus.in_valid = 1'b0;
    tick();
    bus.out_ready = 1'b0;
    chk("b2b_end_ready", 32'(bus.in_ready), 32'd1);

    // Reset while in MY aborts the operation
    drive(0);
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_ready", 32'(bus.in_ready), 32'd1);
    chk("mid_rst_cx", bus.cx, 32'd0);
    chk("mid_rst_cy", bus.cy, 32'd0);
    chk("mid_rst_cz", bus.cz, 32'd0);
    chk("mid_rst_ovf", 32'(bus.ovf), 32'd0);
    tick();
    rst = 1'b0;
    repeat (4) begin
      tick();
      chk("post_rst_valid", 32'(bus.out_valid), 32'd0);
    end
    run_op("post_rst", 0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
